rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 114 +++++++++++
 tb/tb_rf_write_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter. The writeback stage and a buffered
// mul/div result FIFO share one write port; the FIFO wins when the pipe is idle or starved it.
module rf_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic [5:0]  ledreg
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_ent_t;

    wr_ent_t          mem_q [FIFO_DEPTH];
    wr_ent_t          mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_rd_q, rf_rd_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic [5:0]       ledreg_q, ledreg_d;

    logic    pipe_req, fifo_req, grant_fifo, grant_pipe, push;
    wr_ent_t sel;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready looks only at the registered count, so a same-cycle pop never opens a slot.
    assign mdu_ready = (count_q < CNT_W'(FIFO_DEPTH));

    always_comb begin
        pipe_req   = pipe_valid && (pipe_rd != 5'd0);
        fifo_req   = (count_q != '0);
        grant_fifo = fifo_req && (!pipe_req || (starve_q == STV_W'(STARVE_LIMIT)));
        grant_pipe = pipe_req && !grant_fifo;
        push       = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
        pipe_stall = !rst && pipe_req && grant_fifo;
        sel        = grant_fifo ? mem_q[rd_ptr_q] : wr_ent_t'{rd: pipe_rd, data: pipe_data};

        mem_d = mem_q;
        if (push)
            mem_d[wr_ptr_q] = wr_ent_t'{rd: mdu_rd, data: mdu_data};
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = grant_fifo ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        if (push && !grant_fifo)
            count_d = count_q + 1'b1;
        else if (!push && grant_fifo)
            count_d = count_q - 1'b1;

        starve_d = starve_q;
        if (grant_fifo || !fifo_req)
            starve_d = '0;
        else if (grant_pipe && (starve_q != STV_W'(STARVE_LIMIT)))
            starve_d = starve_q + 1'b1;

        rf_we_d    = grant_fifo || grant_pipe;
        rf_rd_d    = rf_we_d ? sel.rd : rf_rd_q;
        rf_wdata_d = rf_we_d ? sel.data : rf_wdata_q;
        ledreg_d   = (rf_we_d && (sel.rd == 5'd5)) ? sel.data[5:0] : ledreg_q;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            ledreg_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            ledreg_q   <= ledreg_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign ledreg   = ledreg_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected writes are queued by the stimulus
// and a negedge monitor pops them whenever rf_we is seen.
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid, mdu_valid;
    logic [4:0]  pipe_rd, mdu_rd;
    logic [31:0] pipe_data, mdu_data;
    logic        pipe_stall, mdu_ready, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [5:0]  ledreg;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    rf_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .ledreg(ledreg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every write the DUT makes must match the head of the queue.
    always @(negedge clk) begin
        if (rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=%0h/%0h required=none", rf_rd, rf_wdata);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rf_rd, rf_wdata} !== e) begin
                    errors++;
                    $display("FAIL rf_write actual=%0h/%0h required=%0h/%0h",
                             rf_rd, rf_wdata, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic expw(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back({rd, d});
    endtask

    // One cycle: apply inputs, check combinational outputs at negedge, advance past the edge.
    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic es, input logic er);
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        mdu_valid  = mv; mdu_rd  = mrd; mdu_data  = md;
        @(negedge clk);
        chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, es});
        chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, er});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic er);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, er);
    endtask

    initial begin
        rst = 1'b1;
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        mdu_valid  = 1'b0; mdu_rd  = '0; mdu_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        // A pipe request while in reset must not produce a write.
        drive(1'b1, 5'd3, 32'h333, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_ledreg", {26'd0, ledreg}, 32'd0);
        rst = 1'b0;
        idle(1'b1);

        // Pipe-only write to x5 updates the display.
        expw(5'd5, 32'h2A);
        drive(1'b1, 5'd5, 32'h2A, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("pipe_ledreg", {26'd0, ledreg}, 32'h2A);
        idle(1'b1);

        // MDU-only: push, grant next cycle, write after that.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 1'b1);
        expw(5'd7, 32'h1234);
        idle(1'b1);
        idle(1'b1);
        chk("mdu_ledreg_hold", {26'd0, ledreg}, 32'h2A);

        // Starvation: three pipe grants with FIFO waiting, then a forced FIFO grant.
        expw(5'd3, 32'h301); drive(1'b1, 5'd3, 32'h301, 1'b1, 5'd9, 32'h900, 1'b0, 1'b1);
        expw(5'd3, 32'h302); drive(1'b1, 5'd3, 32'h302, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        expw(5'd3, 32'h303); drive(1'b1, 5'd3, 32'h303, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        expw(5'd3, 32'h304); drive(1'b1, 5'd3, 32'h304, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        expw(5'd9, 32'h900); drive(1'b1, 5'd3, 32'h305, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        expw(5'd3, 32'h305); drive(1'b1, 5'd3, 32'h305, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        idle(1'b1);

        // Full FIFO with busy pipe; held MDU result; push+pop in one cycle.
        expw(5'd4, 32'h401); drive(1'b1, 5'd4, 32'h401, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b1);
        expw(5'd4, 32'h402); drive(1'b1, 5'd4, 32'h402, 1'b1, 5'd5, 32'hFFFF_FFC7, 1'b0, 1'b1);
        expw(5'd4, 32'h403); drive(1'b1, 5'd4, 32'h403, 1'b1, 5'd12, 32'hC0, 1'b0, 1'b0);
        expw(5'd4, 32'h404); drive(1'b1, 5'd4, 32'h404, 1'b1, 5'd12, 32'hC0, 1'b0, 1'b0);
        expw(5'd10, 32'hA0); drive(1'b1, 5'd4, 32'h405, 1'b1, 5'd12, 32'hC0, 1'b1, 1'b0);
        expw(5'd4, 32'h405); drive(1'b1, 5'd4, 32'h405, 1'b1, 5'd12, 32'hC0, 1'b0, 1'b1);
        expw(5'd5, 32'hFFFF_FFC7); drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        expw(5'd12, 32'hC0); drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hD0, 1'b0, 1'b1);
        expw(5'd13, 32'hD0); idle(1'b1);
        idle(1'b1);
        chk("fifo_ledreg", {26'd0, ledreg}, 32'h07);

        // x0 destinations: no writes, no stall, handshake completes, FIFO stays empty.
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Reset with two buffered entries and a starved pipe.
        expw(5'd6, 32'h601); drive(1'b1, 5'd6, 32'h601, 1'b1, 5'd14, 32'hE0, 1'b0, 1'b1);
        expw(5'd6, 32'h602); drive(1'b1, 5'd6, 32'h602, 1'b1, 5'd15, 32'hF0, 1'b0, 1'b1);
        expw(5'd6, 32'h603); drive(1'b1, 5'd6, 32'h603, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        expw(5'd6, 32'h604); drive(1'b1, 5'd6, 32'h604, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 5'd6, 32'h605, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("post_rst_ledreg", {26'd0, ledreg}, 32'd0);
        chk("post_rst_rf_rd", {27'd0, rf_rd}, 32'd0);
        chk("post_rst_rf_wdata", rf_wdata, 32'd0);

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
